// File: rtl/atm_pkg.sv
// Shared definitions for the ATM core and its keypad front end:
// operation codes, keypad codes, front-end state encoding, field limits.
package atm_pkg;

    // Operation codes understood by the ATM core
    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_DEPOSIT  = 3'd5;
    localparam logic [2:0] OP_CHPIN    = 3'd6;

    // Keypad codes; 0..9 are digits, 14..15 carry no meaning
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] KEY_ENTER     = 4'd10;
    localparam logic [3:0] KEY_CLEAR     = 4'd11;
    localparam logic [3:0] KEY_CANCEL    = 4'd12;
    localparam logic [3:0] KEY_LANG      = 4'd13;

    // Front-end state encoding (also exported on fsm_state)
    typedef logic [3:0] state_t;
    localparam state_t ST_ACC    = 4'd0;
    localparam state_t ST_PIN    = 4'd1;
    localparam state_t ST_OP     = 4'd2;
    localparam state_t ST_AMT    = 4'd3;
    localparam state_t ST_NEWPIN = 4'd4;
    localparam state_t ST_ISSUE  = 4'd5;
    localparam state_t ST_WAIT   = 4'd6;
    localparam state_t ST_RESULT = 4'd7;

    // Number of digits the field edited in state st may hold
    function automatic logic [3:0] field_max_digits(input state_t st, input logic [3:0] amt_digits);
        logic [3:0] max_d;
        case (st)
            ST_ACC:    max_d = 4'd2;
            ST_PIN:    max_d = 4'd4;
            ST_OP:     max_d = 4'd1;
            ST_AMT:    max_d = amt_digits;
            ST_NEWPIN: max_d = 4'd4;
            default:   max_d = 4'd0;
        endcase
        return max_d;
    endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal digit accumulator shared by every keypad field. Each accepted
// digit computes value*10 + d with shifts; digits past max_digits are
// dropped and flagged on drop in the same cycle.
module dec_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [3:0]  digit,
    input  logic [3:0]  max_digits,
    output logic [31:0] value,
    output logic [3:0]  count,
    output logic        drop
);

    logic [31:0] value_r;
    logic [3:0]  count_r;

    assign value = value_r;
    assign count = count_r;
    assign drop  = load & ~clear & (count_r >= max_digits);

    // Buffer and digit counter; clear has priority over a new digit
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= 32'd0;
            count_r <= 4'd0;
        end else if (clear) begin
            value_r <= 32'd0;
            count_r <= 4'd0;
        end else if (load && (count_r < max_digits)) begin
            value_r <= (value_r << 3) + (value_r << 1) + {28'd0, digit};
            count_r <= count_r + 4'd1;
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad-driven transaction initiator for the ATM core: collects account,
// PIN, operation and amount/new PIN, issues a one-cycle start, waits for
// the core's done pulse (or a timeout) and latches the result.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int ACCOUNTS       = 10,
    parameter int AMT_DIGITS     = 9,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        atm_done,
    input  logic [31:0] atm_balance,
    input  logic        atm_success,
    output logic        atm_start,
    output logic [2:0]  operation,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [15:0] new_pin,
    output logic [31:0] amount,
    output logic        language,
    output logic        result_valid,
    output logic [31:0] result_balance,
    output logic        result_success,
    output logic        result_timeout,
    output logic        key_err,
    output logic [3:0]  fsm_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state_r;
    logic [TW-1:0] timer_r;
    logic        atm_start_r, language_r, key_err_r;
    logic [2:0]  operation_r;
    logic [3:0]  acc_num_r;
    logic [15:0] pin_r, new_pin_r;
    logic [31:0] amount_r, result_balance_r;
    logic        result_valid_r, result_success_r, result_timeout_r;

    logic        entry_state_s, idle_state_s, idle_expire_s, go_idle_s, lang_toggle_s;
    logic        acc_clear_s, acc_load_s, acc_drop_s, enter_ok_s;
    logic [31:0] acc_value_s;
    logic [3:0]  acc_count_s;
    state_t      enter_next_s;

    assign atm_start      = atm_start_r;
    assign operation      = operation_r;
    assign acc_num        = acc_num_r;
    assign pin            = pin_r;
    assign new_pin        = new_pin_r;
    assign amount         = amount_r;
    assign language       = language_r;
    assign result_valid   = result_valid_r;
    assign result_balance = result_balance_r;
    assign result_success = result_success_r;
    assign result_timeout = result_timeout_r;
    assign key_err        = key_err_r;
    assign fsm_state      = state_r;

    assign entry_state_s = (state_r <= ST_NEWPIN);
    assign idle_state_s  = entry_state_s && (state_r != ST_ACC);
    assign idle_expire_s = idle_state_s && !key_valid && (timer_r == TW'(TIMEOUT_CYCLES - 1));
    // Every path back to ACC that discards the request fields
    assign go_idle_s     = idle_expire_s || (state_r == ST_RESULT) ||
                           (key_valid && (key_code == KEY_CANCEL) && (state_r != ST_WAIT));
    assign lang_toggle_s = key_valid && (key_code == KEY_LANG) && (state_r != ST_WAIT);

    dec_accumulator u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear_s),
        .load       (acc_load_s),
        .digit      (key_code),
        .max_digits (field_max_digits(state_r, 4'(AMT_DIGITS))),
        .value      (acc_value_s),
        .count      (acc_count_s),
        .drop       (acc_drop_s)
    );

    // Route digits into the shared buffer and clear it on ENTER/CLEAR/CANCEL/inactivity
    always_comb begin
        acc_clear_s = 1'b0;
        acc_load_s  = 1'b0;
        if (entry_state_s && key_valid) begin
            if (key_code <= KEY_MAX_DIGIT) begin
                acc_load_s = 1'b1;
            end else if ((key_code == KEY_ENTER) || (key_code == KEY_CLEAR) || (key_code == KEY_CANCEL)) begin
                acc_clear_s = 1'b1;
            end else begin
                acc_clear_s = 1'b0;
            end
        end else if (idle_expire_s) begin
            acc_clear_s = 1'b1;
        end else begin
            acc_clear_s = 1'b0;
        end
    end

    // Validate the buffer for the current field and pick the state ENTER leads to
    always_comb begin
        enter_ok_s   = 1'b0;
        enter_next_s = state_r;
        case (state_r)
            ST_ACC: begin
                if ((acc_value_s >= 32'd1) && (acc_value_s <= 32'(ACCOUNTS))) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_PIN;
                end else begin
                    enter_ok_s   = 1'b0;
                end
            end
            ST_PIN: begin
                if (acc_count_s == 4'd4) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_OP;
                end else begin
                    enter_ok_s   = 1'b0;
                end
            end
            ST_OP: begin
                if (acc_value_s == {29'd0, OP_BALANCE}) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_ISSUE;
                end else if ((acc_value_s == {29'd0, OP_WITHDRAW}) || (acc_value_s == {29'd0, OP_DEPOSIT})) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_AMT;
                end else if (acc_value_s == {29'd0, OP_CHPIN}) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_NEWPIN;
                end else begin
                    enter_ok_s   = 1'b0;
                end
            end
            ST_AMT: begin
                if ((acc_count_s != 4'd0) && (acc_value_s != 32'd0)) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_ISSUE;
                end else begin
                    enter_ok_s   = 1'b0;
                end
            end
            ST_NEWPIN: begin
                if (acc_count_s == 4'd4) begin
                    enter_ok_s   = 1'b1;
                    enter_next_s = ST_ISSUE;
                end else begin
                    enter_ok_s   = 1'b0;
                end
            end
            default: begin
                enter_ok_s   = 1'b0;
                enter_next_s = state_r;
            end
        endcase
    end

    // Transaction FSM with registered request, result and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_ACC;
            timer_r          <= {TW{1'b0}};
            atm_start_r      <= 1'b0;
            operation_r      <= 3'd0;
            acc_num_r        <= 4'd0;
            pin_r            <= 16'd0;
            new_pin_r        <= 16'd0;
            amount_r         <= 32'd0;
            language_r       <= 1'b0;
            result_valid_r   <= 1'b0;
            result_balance_r <= 32'd0;
            result_success_r <= 1'b0;
            result_timeout_r <= 1'b0;
            key_err_r        <= 1'b0;
        end else begin
            atm_start_r    <= 1'b0;
            key_err_r      <= 1'b0;
            result_valid_r <= 1'b0;
            if (lang_toggle_s) begin
                language_r <= ~language_r;
            end
            if (go_idle_s) begin
                state_r     <= ST_ACC;
                timer_r     <= {TW{1'b0}};
                operation_r <= 3'd0;
                acc_num_r   <= 4'd0;
                pin_r       <= 16'd0;
                new_pin_r   <= 16'd0;
                amount_r    <= 32'd0;
                key_err_r   <= idle_expire_s;
            end else begin
                case (state_r)
                    ST_ACC, ST_PIN, ST_OP, ST_AMT, ST_NEWPIN: begin
                        if (key_valid) begin
                            timer_r <= {TW{1'b0}};
                            if (key_code == KEY_ENTER) begin
                                if (enter_ok_s) begin
                                    state_r     <= enter_next_s;
                                    atm_start_r <= (enter_next_s == ST_ISSUE);
                                    case (state_r)
                                        ST_ACC:    acc_num_r   <= acc_value_s[3:0];
                                        ST_PIN:    pin_r       <= acc_value_s[15:0];
                                        ST_OP:     operation_r <= acc_value_s[2:0];
                                        ST_AMT:    amount_r    <= acc_value_s;
                                        ST_NEWPIN: new_pin_r   <= acc_value_s[15:0];
                                        default:   begin end
                                    endcase
                                end else begin
                                    key_err_r <= 1'b1;
                                end
                            end else if (acc_drop_s) begin
                                key_err_r <= 1'b1;
                            end
                        end else if (state_r != ST_ACC) begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                    ST_ISSUE: begin
                        state_r <= ST_WAIT;
                        timer_r <= {TW{1'b0}};
                    end
                    ST_WAIT: begin
                        if (atm_done) begin
                            result_balance_r <= atm_balance;
                            result_success_r <= atm_success;
                            result_timeout_r <= 1'b0;
                            result_valid_r   <= 1'b1;
                            state_r          <= ST_RESULT;
                            timer_r          <= {TW{1'b0}};
                        end else if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
                            result_balance_r <= 32'd0;
                            result_success_r <= 1'b0;
                            result_timeout_r <= 1'b1;
                            result_valid_r   <= 1'b1;
                            state_r          <= ST_RESULT;
                            timer_r          <= {TW{1'b0}};
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_ACC;
                        timer_r <= {TW{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Transaction initiator for the ATM core. It turns a stream of keypad key codes into a complete transaction: account number, PIN, operation, and amount or new PIN. It drives the core's request fields, issues a one-cycle start, waits for the core's done pulse, and latches the returned balance and success flag for the display path. It is the driving end of the ATM core's request/response interface.

## Interface
- `ACCOUNTS`, 10, highest valid account number; valid accounts are 1..ACCOUNTS.
- `AMT_DIGITS`, 9, maximum decimal digits in an amount. Must be ≤ 9 so the value fits in 32 bits.
- `TIMEOUT_CYCLES`, 1000, inactivity limit and core-response limit, in clk cycles.
- `clk  in  1` — single clock, rising edge.
- `rst  in  1` — synchronous reset, active-high.
- `key_valid  in  1` — key strobe; at most one key per cycle.
- `key_code  in  4` — keypad code:
  - 0–9: digit
  - 10: ENTER
  - 11: CLEAR
  - 12: CANCEL
  - 13: LANG
  - 14–15: ignored
- `atm_done  in  1` — one-cycle completion pulse from the core.
- `atm_balance  in  32` — core balance; valid in the `atm_done` cycle.
- `atm_success  in  1` — core success flag; valid in the `atm_done` cycle.
- `atm_start  out  1` — one-cycle transaction request to the core.
- `operation  out  3` — 3 = balance, 4 = withdraw, 5 = deposit, 6 = change PIN.
- `acc_num  out  4` — account number.
- `pin  out  16` — PIN as the binary value of 4 decimal digits (keys 1,2,3,4 → 16'd1234).
- `new_pin  out  16` — new PIN, same encoding as `pin`.
- `amount  out  32` — binary amount.
- `language  out  1` — toggled by LANG.
- `result_valid  out  1` — one-cycle pulse when a result is latched.
- `result_balance  out  32` — latched result balance.
- `result_success  out  1` — latched result success.
- `result_timeout  out  1` — latched flag: the core did not respond.
- `key_err  out  1` — one-cycle pulse on a rejected key or field.
- `fsm_state  out  4` — current state encoding, for debug.

## Operation
- States: ACC, PIN, OP, AMT, NEWPIN, ISSUE, WAIT, RESULT. ACC is the idle/entry state.
- Digit accumulation into the field buffer: `buf = buf*10 + d`, computed as `(buf<<3)+(buf<<1)+d`. A digit counter runs alongside.
- Digit limits per field: ACC 2, PIN 4, OP 1, AMT AMT_DIGITS, NEWPIN 4. A digit beyond the limit is dropped and pulses `key_err`.
- CLEAR zeroes the buffer and digit count; the state is unchanged.
- LANG toggles `language` in any state except WAIT.
- CANCEL (any state except WAIT):
  - go to ACC;
  - clear all fields and buffers;
  - no `atm_start`.
- ENTER validation; on failure pulse `key_err`, clear the buffer, and stay in the current state:
  - ACC: requires 1 ≤ buf ≤ ACCOUNTS. On success latch `acc_num` and go to PIN.
  - PIN: requires exactly 4 digits. On success latch `pin` and go to OP.
  - OP: requires buf ∈ {3,4,5,6}. Then go to:
    - ISSUE for 3;
    - AMT for 4 and 5;
    - NEWPIN for 6.
  - AMT: requires ≥ 1 digit and a nonzero value. On success latch `amount` and go to ISSUE.
  - NEWPIN: requires exactly 4 digits. On success latch `new_pin` and go to ISSUE.
- `amount` is forced to 0 for op 3 and op 6. `new_pin` is forced to 0 unless op is 6.
- ISSUE: assert `atm_start` for exactly one cycle, then go to WAIT. Request fields hold stable from ISSUE until RESULT is left.
- WAIT: keys are ignored.
  - `atm_done` → latch `atm_balance` and `atm_success`, clear `result_timeout`, go to RESULT.
  - TIMEOUT_CYCLES cycles without `atm_done` → latch balance 0, success 0, timeout 1, go to RESULT.
- RESULT: pulse `result_valid` for one cycle, then go to ACC and clear the request fields. Result registers hold until the next result.
- Inactivity: in PIN, OP, AMT or NEWPIN, TIMEOUT_CYCLES cycles with no `key_valid` act as CANCEL and also pulse `key_err`. The counter reloads on every accepted key.

## Timing
- Reset:
  - all outputs are 0, including `language`;
  - state is ACC;
  - counters are 0.
- A reset in any state, including WAIT, aborts without `atm_start` or `result_valid`. An `atm_done` arriving after a reset is ignored, since the block is in ACC.
- A key is registered on the edge where `key_valid` is high. The state change is visible the next cycle.
- Last ENTER → `atm_start` high exactly 1 cycle later (the ISSUE cycle).
- `atm_done` in cycle t → `result_valid`, `result_balance` and `result_success` all valid in cycle t+1.
- `atm_done` in the same cycle as the WAIT timeout expiry: `atm_done` wins.
- `atm_done` outside WAIT is ignored.
- The WAIT timeout counts from the first WAIT cycle; `result_valid` occurs at most TIMEOUT_CYCLES+1 cycles after `atm_start`.

## Structure
- Shared package `atm_pkg`:
  - operation codes (OP_BALANCE = 3, OP_WITHDRAW = 4, OP_DEPOSIT = 5, OP_CHPIN = 6);
  - key codes;
  - the state enum.
- The ATM core imports the same package.
- Sub-module `dec_accumulator`: 32-bit buffer, digit counter, clear/load/digit inputs, max-digit input. It is instantiated once and shared across fields.

## Test plan
- Balance: keys 1,ENTER,1,2,3,4,ENTER,3,ENTER.
  - Expect `atm_start` with `acc_num` = 1, `pin` = 1234, `operation` = 3, `amount` = 0.
  - Model `atm_done` with balance 1000, success 1 → `result_valid` one cycle later, `result_balance` = 1000, `result_success` = 1.
- Deposit: keys 2,ENTER,2,3,4,5,ENTER,5,ENTER,1,0,0,0,ENTER.
  - Expect `operation` = 5, `amount` = 1000.
  - Core returns 3000 → `result_balance` = 3000.
- Bad fields:
  - account 11 → `key_err`, stays in ACC;
  - PIN 1,2,3 then ENTER → `key_err`, stays in PIN;
  - op 7 → `key_err`;
  - none of these produce an `atm_start`.
- Change PIN: account 1, PIN 1234, op 6, new PIN 5678 → `new_pin` = 5678, `amount` = 0.
  - Core returns success 0 → `result_success` = 0.
- Timeouts:
  - no key for TIMEOUT_CYCLES in PIN → returns to ACC with `key_err`;
  - no `atm_done` for TIMEOUT_CYCLES in WAIT → `result_valid` with `result_timeout` = 1, `result_success` = 0.
- CANCEL and reset:
  - CANCEL mid-AMT → ACC, fields zero, no `atm_start`;
  - `rst` in WAIT, then `atm_done` → no `result_valid`, all outputs 0.
